// File: rtl/rv_mdu_pkg.sv
// Shared encodings and types for the RV32IM multiply/divide unit.
// The divider's funct3 codes and FSM states live here.
package rv_mdu_pkg;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and keep the result if no borrow.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;
   logic          w_borrow;

   // The extra MSB of the trial difference is the borrow out of the subtraction.
   assign w_shift  = {i_rem, i_quo[XLEN-1]};
   assign w_diff   = w_shift - {1'b0, i_divisor};
   assign w_borrow = w_diff[XLEN];

   assign o_rem = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
   assign o_quo = {i_quo[XLEN-2:0], ~w_borrow};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU in the Execute stage.
// Stalls the front of the pipeline while a divide is in flight.
module div_unit
   import rv_mdu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   div_state_t       r_state;
   div_state_t       w_state_nxt;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [XLEN-1:0]  r_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_is_rem;
   logic             r_done;
   logic [XLEN-1:0]  r_result;

   logic            w_signed;
   logic            w_is_rem;
   logic [XLEN-1:0] w_a_abs;
   logic [XLEN-1:0] w_b_abs;
   logic            w_accept;
   logic            w_b_zero;
   logic            w_ovf;
   logic            w_fast;
   logic            w_last;
   logic [XLEN-1:0] w_fast_result;
   logic [XLEN-1:0] w_rem_nxt;
   logic [XLEN-1:0] w_quo_nxt;
   logic [XLEN-1:0] w_calc_result;

   assign w_signed = (funct3 == F3_DIV) | (funct3 == F3_REM);
   assign w_is_rem = (funct3 == F3_REM) | (funct3 == F3_REMU);
   assign w_a_abs  = (w_signed & a[XLEN-1]) ? -a : a;
   assign w_b_abs  = (w_signed & b[XLEN-1]) ? -b : b;
   assign w_accept = (r_state == IDLE) & start & ~flush;
   assign w_b_zero = (b == '0);
   assign w_ovf    = w_signed & (a == INT_MIN) & (b == '1);
   assign w_fast   = w_b_zero | w_ovf;
   assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

   // Divide-by-zero and signed overflow have architecturally fixed answers.
   assign w_fast_result = w_b_zero ? (w_is_rem ? a : '1)
                                   : (w_is_rem ? '0 : INT_MIN);

   div_step #(.XLEN(XLEN)) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_div),
      .o_rem     (w_rem_nxt),
      .o_quo     (w_quo_nxt)
   );

   assign w_calc_result = r_is_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                                   : (r_neg_q ? -w_quo_nxt : w_quo_nxt);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: default assignment first so no path through the case leaves w_state_nxt unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = w_fast ? DONE : CALC;
         CALC:    if (w_last)   w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (flush) w_state_nxt = IDLE;
   end

   always_comb begin
      stall  = w_accept | (r_state == CALC);
      done   = r_done;
      result = r_result;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_rem <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= (w_state_nxt == DONE);
         if (w_accept) begin
            r_rem    <= '0;
            r_quo    <= w_a_abs;
            r_div    <= w_b_abs;
            r_cnt    <= '0;
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_signed & (a[XLEN-1] ^ b[XLEN-1]);
            r_neg_r  <= w_signed & a[XLEN-1];
            if (w_fast) r_result <= w_fast_result;
         end else if ((r_state == CALC) && !flush) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_result <= w_calc_result;
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table through a result scoreboard,
// plus flush, back-to-back, and mid-operation reset sequences.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] a;
   logic [31:0] b;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_exp = 32'd0;

   localparam logic [2:0] DIV  = 3'b100;
   localparam logic [2:0] DIVU = 3'b101;
   localparam logic [2:0] REM  = 3'b110;
   localparam logic [2:0] REMU = 3'b111;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[20];

   div_unit dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .a      (a),
      .b      (b),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Launch one divide at the next negedge (cycle 0) and wait for its done pulse.
   task automatic do_div(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp, input int lat, input string name);
      logic got;
      logic stall_bad;
      int   cyc;
      @(negedge clk);
      funct3 = f3; a = av; b = bv; start = 1'b1;
      sb_q.push_back(exp);
      got = 1'b0; stall_bad = 1'b0; cyc = 0;
      while (!got && cyc <= 60) begin
         #1;
         if (done) begin
            got = 1'b1;
            check({name, "_latency"}, 32'(cyc), 32'(lat));
            if (sb_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL %s_scoreboard: got done expected no pending result", name);
            end else begin
               check(name, result, sb_q.pop_front());
            end
            check({name, "_stall_in_done"}, {31'd0, stall}, 32'd0);
            start = 1'b0;
         end else begin
            if (stall !== 1'b1) stall_bad = 1'b1;
            @(negedge clk);
            cyc++;
         end
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout: got no done expected done at cycle %0d", name, lat);
         sb_q.delete();
         start = 1'b0;
      end else begin
         check({name, "_stall_busy"}, {31'd0, stall_bad}, 32'd0);
         last_exp = exp;
         @(negedge clk);
         #1;
         check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
         check({name, "_hold"}, result, exp);
      end
   endtask

   initial begin
      int   first_cyc;
      int   second_cyc;
      int   n_done;
      logic seen_done;

      vecs[0]  = '{DIVU, 32'd100,        32'd7,        32'd14,         33, "divu_100_7"};
      vecs[1]  = '{REMU, 32'd100,        32'd7,        32'd2,          33, "remu_100_7"};
      vecs[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  33, "div_m7_2"};
      vecs[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  33, "rem_m7_2"};
      vecs[4]  = '{DIVU, 32'd5,          32'd0,        32'hFFFF_FFFF,  1,  "divu_5_0"};
      vecs[5]  = '{REM,  32'd5,          32'd0,        32'd5,          1,  "rem_5_0"};
      vecs[6]  = '{DIV,  32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF,  1,  "div_m5_0"};
      vecs[7]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf"};
      vecs[8]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf"};
      vecs[9]  = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33, "divu_ovf_ops"};
      vecs[10] = '{DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2"};
      vecs[11] = '{REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         33, "rem_7_m2"};
      vecs[12] = '{DIVU, 32'hFFFF_FFFF,  32'd10,       32'h1999_9999,  33, "divu_max_10"};
      vecs[13] = '{REMU, 32'hFFFF_FFFF,  32'd10,       32'd5,          33, "remu_max_10"};
      vecs[14] = '{DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        33, "div_m100_m7"};
      vecs[15] = '{REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, "rem_m100_m7"};
      vecs[16] = '{DIV,  32'h8000_0000,  32'd1,        32'h8000_0000,  33, "div_min_1"};
      vecs[17] = '{REMU, 32'd3,          32'd5,        32'd3,          33, "remu_3_5"};
      vecs[18] = '{DIVU, 32'd0,          32'd5,        32'd0,          33, "divu_0_5"};
      vecs[19] = '{REMU, 32'd0,          32'd0,        32'd0,          1,  "remu_0_0"};

      reset = 1'b0; start = 1'b0; flush = 1'b0; funct3 = DIVU; a = '0; b = '0;
      #3;
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_stall_idle", {31'd0, stall}, 32'd0);
      start = 1'b1;
      #1;
      check("reset_stall_start", {31'd0, stall}, 32'd1);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 20; i++)
         do_div(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

      // Flush in CALC at cycle 10: back to IDLE at 11 with no done, result held.
      @(negedge clk);
      funct3 = DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (done) seen_done = 1'b1;
         @(negedge clk);
      end
      flush = 1'b1;
      #1;
      check("flush_stall_calc", {31'd0, stall}, 32'd1);
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      #1;
      check("flush_no_done", {31'd0, (done | seen_done)}, 32'd0);
      check("flush_idle_stall", {31'd0, stall}, 32'd0);
      check("flush_result_held", result, last_exp);
      do_div(DIVU, 32'd1000, 32'd3, 32'd333, 33, "divu_after_flush");

      // Flush wins over start in IDLE: nothing is accepted.
      @(negedge clk);
      funct3 = DIVU; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
      #1;
      check("flush_beats_start_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("flush_beats_start_idle", {31'd0, stall}, 32'd0);
      check("flush_beats_start_done", {31'd0, done}, 32'd0);

      // Back-to-back: start held through DONE, second op accepted in the following IDLE cycle.
      @(negedge clk);
      funct3 = DIVU; a = 32'd9; b = 32'd3; start = 1'b1;
      sb_q.push_back(32'd3);
      sb_q.push_back(32'd5);
      first_cyc = -1; second_cyc = -1; n_done = 0;
      for (int c = 0; c < 90 && n_done < 2; c++) begin
         #1;
         if (done) begin
            n_done++;
            if (sb_q.size() != 0) check($sformatf("b2b_result_%0d", n_done), result, sb_q.pop_front());
            if (n_done == 1) begin
               first_cyc = c;
               a = 32'd21; b = 32'd4;
            end else begin
               second_cyc = c;
               start = 1'b0;
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("b2b_first_cycle", 32'(first_cyc), 32'd33);
      check("b2b_second_cycle", 32'(second_cyc), 32'd67);
      sb_q.delete();
      last_exp = 32'd5;
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of a signed divide.
      @(negedge clk);
      funct3 = DIV; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
      repeat (20) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midreset_done", {31'd0, done}, 32'd0);
      check("midreset_result", result, 32'd0);
      check("midreset_stall_start", {31'd0, stall}, 32'd1);
      start = 1'b0;
      #1;
      check("midreset_stall_idle", {31'd0, stall}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      check("midreset_no_done", {31'd0, seen_done}, 32'd0);
      do_div(DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_after_reset");

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
